// File: rtl/seq_gen_pkg.sv
// Shared definitions for the programmable serial pattern generator:
// FSM state encoding, reset-time defaults and the length-field width helper.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    localparam logic [15:0] SEQ_DEFAULT_PATTERN = 16'h0139;
    localparam int unsigned SEQ_DEFAULT_LEN     = 9;

    // Width needed to hold a bit count in the range 0..max_len.
    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_pattern_generator_if.sv
// Valid/ready serial link between the pattern generator (master) and the
// downstream consumer (slave).
interface seq_pattern_generator_if;

    logic ser_valid;
    logic ser_ready;
    logic serial_out;

    modport master (
        output ser_valid,
        output serial_out,
        input  ser_ready
    );

    modport slave (
        input  ser_valid,
        input  serial_out,
        output ser_ready
    );

endinterface

// File: rtl/seq_gen_shifter.sv
// Datapath of the pattern generator: latched pattern/length, bit index,
// history shift register and running parity of emitted bits.
module seq_gen_shifter
    import seq_gen_pkg::*;
#(
    parameter int unsigned          MAX_LEN         = 16,
    parameter int unsigned          LEN_W           = len_width(MAX_LEN),
    parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = MAX_LEN'(SEQ_DEFAULT_PATTERN),
    parameter int unsigned          DEFAULT_LEN     = SEQ_DEFAULT_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [MAX_LEN-1:0] load_pattern,
    input  logic [LEN_W-1:0]   load_len,
    input  logic               clear,
    input  logic               advance,
    input  logic               restart,
    output logic               cur_bit,
    output logic               is_last,
    output logic               par_bit,
    output logic [MAX_LEN-1:0] seq_out
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   idx;
    logic               par_acc;
    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   bit_pos;
    logic [MAX_LEN-1:0] pattern_shifted;

    // Select the current pattern bit (MSB of the active length first) and clamp incoming lengths.
    always_comb begin
        len_clamped = load_len;
        if (load_len == '0 || load_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
        bit_pos         = len_r - LEN_ONE - idx;
        pattern_shifted = pattern_r >> bit_pos;
        cur_bit         = pattern_shifted[0];
        is_last         = (idx == len_r - LEN_ONE);
        par_bit         = par_acc;
    end

    // Configuration, index, history and parity registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_r <= DEFAULT_PATTERN;
            len_r     <= LEN_W'(DEFAULT_LEN);
            idx       <= '0;
            seq_out   <= '0;
            par_acc   <= 1'b0;
        end else begin
            if (load) begin
                pattern_r <= load_pattern;
                len_r     <= len_clamped;
            end
            if (clear) begin
                idx     <= '0;
                seq_out <= '0;
                par_acc <= 1'b0;
            end else begin
                if (advance) begin
                    seq_out <= {seq_out[MAX_LEN-2:0], cur_bit};
                end
                // restart wins over the index/parity update so a wrapping
                // last-bit transfer lands directly on bit 0 of the next pass.
                if (restart) begin
                    idx     <= '0;
                    par_acc <= 1'b0;
                end else if (advance) begin
                    idx     <= idx + LEN_ONE;
                    par_acc <= par_acc ^ cur_bit;
                end
            end
        end
    end

endmodule

// File: rtl/seq_pattern_generator.sv
// Programmable serial pattern generator: emits up to MAX_LEN bits MSB first
// over a valid/ready link, one-shot or continuous, with abort and a
// completed-sequence counter.
// Optional feature macro: SEQ_GEN_PARITY_EN appends an even-parity bit
// after every pattern pass.
module seq_pattern_generator
    import seq_gen_pkg::*;
#(
    parameter int unsigned          MAX_LEN         = 16,
    parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = MAX_LEN'(SEQ_DEFAULT_PATTERN),
    parameter int unsigned          DEFAULT_LEN     = SEQ_DEFAULT_LEN,
    parameter int unsigned          CNT_W           = 8,
    parameter int unsigned          LEN_W           = len_width(MAX_LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_load,
    input  logic [MAX_LEN-1:0]       cfg_pattern,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     cont_mode,
    input  logic                     start,
    input  logic                     stop,
    seq_pattern_generator_if.master  ser,
    output logic [MAX_LEN-1:0]       seq_out,
    output logic                     seq_done,
    output logic [CNT_W-1:0]         seq_count,
    output logic [1:0]               state_out
);

    state_t state;
    state_t state_nx;
    logic   sh_load;
    logic   sh_clear;
    logic   sh_advance;
    logic   sh_restart;
    logic   cur_bit;
    logic   is_last;
    logic   par_bit;
    logic   done_nx;

    seq_gen_shifter #(
        .MAX_LEN         (MAX_LEN),
        .LEN_W           (LEN_W),
        .DEFAULT_PATTERN (DEFAULT_PATTERN),
        .DEFAULT_LEN     (DEFAULT_LEN)
    ) u_shifter (
        .clk          (clk),
        .rst          (rst),
        .load         (sh_load),
        .load_pattern (cfg_pattern),
        .load_len     (cfg_len),
        .clear        (sh_clear),
        .advance      (sh_advance),
        .restart      (sh_restart),
        .cur_bit      (cur_bit),
        .is_last      (is_last),
        .par_bit      (par_bit),
        .seq_out      (seq_out)
    );

    // State, completion pulse and completed-sequence counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            seq_done  <= 1'b0;
            seq_count <= '0;
        end else begin
            state    <= state_nx;
            seq_done <= done_nx;
            if (done_nx) begin
                seq_count <= seq_count + CNT_W'(1);
            end
        end
    end

    // Next-state, handshake outputs and datapath controls.
    always_comb begin
        state_nx       = state;
        ser.ser_valid  = 1'b0;
        ser.serial_out = 1'b0;
        sh_load        = 1'b0;
        sh_clear       = 1'b0;
        sh_advance     = 1'b0;
        sh_restart     = 1'b0;
        done_nx        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                sh_load = cfg_load;
                if (start) begin
                    sh_clear = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                ser.ser_valid  = 1'b1;
                ser.serial_out = cur_bit;
                if (ser.ser_ready) begin
                    sh_advance = 1'b1;
                    if (is_last) begin
`ifdef SEQ_GEN_PARITY_EN
                        state_nx = stop ? ST_IDLE : ST_PAR;
`else
                        done_nx = 1'b1;
                        if (cont_mode && !stop) begin
                            sh_restart = 1'b1;
                        end else begin
                            state_nx = ST_IDLE;
                        end
`endif
                    end else if (stop) begin
                        state_nx = ST_IDLE;
                    end
                end else if (stop) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_PAR: begin
                ser.ser_valid  = 1'b1;
                ser.serial_out = par_bit;
                if (ser.ser_ready) begin
                    done_nx = 1'b1;
                    if (cont_mode && !stop) begin
                        sh_restart = 1'b1;
                        state_nx   = ST_RUN;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else if (stop) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign state_out = state;

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Directed, table-driven bench for seq_pattern_generator (default build).
module tb_seq_pattern_generator;
    import seq_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_load = 1'b0;
    logic [15:0] cfg_pattern = '0;
    logic [4:0]  cfg_len = '0;
    logic        cont_mode = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] seq_out;
    logic        seq_done;
    logic [7:0]  seq_count;
    logic [1:0]  state_out;

    int n_checks = 0;
    int n_fail   = 0;

    seq_pattern_generator_if ser_if ();

    seq_pattern_generator #(
        .MAX_LEN (16),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cont_mode   (cont_mode),
        .start       (start),
        .stop        (stop),
        .ser         (ser_if.master),
        .seq_out     (seq_out),
        .seq_done    (seq_done),
        .seq_count   (seq_count),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;

    typedef struct {
        logic        load;
        logic [15:0] pat;
        logic [4:0]  len;
        logic        cont;
        logic        st;
        logic        sp;
        logic        rdy;
        logic        ev;
        logic        eb;
        logic        ed;
        logic [1:0]  es;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic ld, input logic [15:0] pat, input logic [4:0] len,
                                input logic cont, input logic st, input logic sp, input logic rdy,
                                input logic ev, input logic eb, input logic ed, input logic [1:0] es);
        vec_t v;
        v.load = ld; v.pat = pat; v.len = len; v.cont = cont; v.st = st; v.sp = sp; v.rdy = rdy;
        v.ev = ev; v.eb = eb; v.ed = ed; v.es = es;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each vector: compare outputs of the current cycle, then drive its inputs for the next edge.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s[%0d] {valid,bit,done,state}", tag, i),
                  {27'd0, ser_if.ser_valid, ser_if.serial_out, seq_done, state_out},
                  {27'd0, vecs[i].ev, vecs[i].eb, vecs[i].ed, vecs[i].es});
            cfg_load         = vecs[i].load;
            cfg_pattern      = vecs[i].pat;
            cfg_len          = vecs[i].len;
            cont_mode        = vecs[i].cont;
            start            = vecs[i].st;
            stop             = vecs[i].sp;
            ser_if.ser_ready = vecs[i].rdy;
        end
        vecs.delete();
    endtask

    task automatic add_tail();
        add(0, 16'h0, 5'd0, 0, 0, 0, 0, 0, 0, 1, S_IDLE);
        add(0, 16'h0, 5'd0, 0, 0, 0, 0, 0, 0, 0, S_IDLE);
    endtask

    // Full one-shot sequence with ready held high.
    task automatic add_plain_seq(input logic ld, input logic [15:0] ld_len_pat, input logic [4:0] ld_len,
                                 input logic [15:0] pat, input int len);
        add(ld, ld_len_pat, ld_len, 0, 1, 0, 1, 0, 0, 0, S_IDLE);
        for (int k = 0; k < len; k++) add(0, 16'h0, 5'd0, 0, 0, 0, 1, 1, pat[len-1-k], 0, S_RUN);
        add_tail();
    endtask

    task automatic check_regs(input string tag, input logic [15:0] e_out, input logic [7:0] e_cnt);
        @(negedge clk);
        check({tag, " seq_out"}, {16'd0, seq_out}, {16'd0, e_out});
        check({tag, " seq_count"}, {24'd0, seq_count}, {24'd0, e_cnt});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        cfg_load = 0; cont_mode = 0; start = 0; stop = 0; ser_if.ser_ready = 0;
        repeat (2) @(negedge clk);
        check("reset {valid,bit,done,state}",
              {27'd0, ser_if.ser_valid, ser_if.serial_out, seq_done, state_out}, 32'd0);
        check("reset seq_out", {16'd0, seq_out}, 32'd0);
        check("reset seq_count", {24'd0, seq_count}, 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] def_pat;
        logic [15:0] pat;
        int j;
        int k;
        logic rdy;
        def_pat = 16'h0139;
        ser_if.ser_ready = 1'b0;

        // Reset defaults and plain default run.
        do_reset();
        add_plain_seq(0, 16'h0, 5'd0, def_pat, 9);
        run_vecs("default");
        check_regs("default", 16'h0139, 8'd1);

        // Backpressure: ready pattern 1,0,0,1 repeating while running.
        add(0, 16'h0, 5'd0, 0, 1, 0, 0, 0, 0, 0, S_IDLE);
        j = 0; k = 0;
        while (j < 9) begin
            rdy = (k % 4 == 0) || (k % 4 == 3);
            add(0, 16'h0, 5'd0, 0, 0, 0, rdy, 1, def_pat[8-j], 0, S_RUN);
            if (rdy) j++;
            k++;
        end
        add_tail();
        run_vecs("backpressure");
        check_regs("backpressure", 16'h0139, 8'd2);

        // Continuous mode with load+start together; cont dropped on the last bit of the third pass.
        do_reset();
        pat = 16'h000B;
        add(1, pat, 5'd4, 1, 1, 0, 1, 0, 0, 0, S_IDLE);
        for (int c = 0; c < 12; c++)
            add(0, 16'h0, 5'd0, (c != 11), 0, 0, 1, 1, pat[3 - (c % 4)], (c == 4 || c == 8), S_RUN);
        add_tail();
        run_vecs("continuous");
        check_regs("continuous", 16'h0BBB, 8'd3);

        // Abort after three accepted bits (stop with ready low).
        do_reset();
        add(0, 16'h0, 5'd0, 0, 1, 0, 1, 0, 0, 0, S_IDLE);
        for (int c = 0; c < 3; c++) add(0, 16'h0, 5'd0, 0, 0, 0, 1, 1, def_pat[8-c], 0, S_RUN);
        add(0, 16'h0, 5'd0, 0, 0, 1, 0, 1, def_pat[5], 0, S_RUN);
        add(0, 16'h0, 5'd0, 0, 0, 0, 0, 0, 0, 0, S_IDLE);
        add(0, 16'h0, 5'd0, 0, 0, 0, 0, 0, 0, 0, S_IDLE);
        run_vecs("abort");
        check_regs("abort", 16'h0004, 8'd0);

        // Stop coincident with the last bit in continuous mode.
        pat = 16'h000B;
        add(1, pat, 5'd4, 1, 1, 0, 1, 0, 0, 0, S_IDLE);
        for (int c = 0; c < 4; c++) add(0, 16'h0, 5'd0, 1, 0, (c == 3), 1, 1, pat[3-c], 0, S_RUN);
        add_tail();
        run_vecs("stop_last");
        check_regs("stop_last", 16'h000B, 8'd1);

        // Length 1: every transfer completes a sequence.
        add(1, 16'h0001, 5'd1, 1, 1, 0, 1, 0, 0, 0, S_IDLE);
        add(0, 16'h0, 5'd0, 1, 0, 0, 1, 1, 1, 0, S_RUN);
        add(0, 16'h0, 5'd0, 1, 0, 0, 1, 1, 1, 1, S_RUN);
        add(0, 16'h0, 5'd0, 0, 0, 0, 1, 1, 1, 1, S_RUN);
        add_tail();
        run_vecs("len1");
        check_regs("len1", 16'h0007, 8'd4);

        // Length 0 clamps to 16.
        add_plain_seq(1, 16'hA5C3, 5'd0, 16'hA5C3, 16);
        run_vecs("len0");
        check_regs("len0", 16'hA5C3, 8'd5);

        // Load during RUN is ignored.
        pat = 16'hA5C3;
        add(0, 16'h0, 5'd0, 0, 1, 0, 1, 0, 0, 0, S_IDLE);
        for (int c = 0; c < 16; c++)
            add((c == 1), 16'h0000, 5'd2, 0, 0, 0, 1, 1, pat[15-c], 0, S_RUN);
        add_tail();
        run_vecs("load_in_run");
        check_regs("load_in_run", 16'hA5C3, 8'd6);

        // Length above MAX_LEN clamps to 16.
        add_plain_seq(1, 16'h5A3C, 5'd20, 16'h5A3C, 16);
        run_vecs("len20");
        check_regs("len20", 16'h5A3C, 8'd7);

        // Asynchronous reset in the middle of a sequence.
        pat = 16'h5A3C;
        add(0, 16'h0, 5'd0, 0, 1, 0, 1, 0, 0, 0, S_IDLE);
        add(0, 16'h0, 5'd0, 0, 0, 0, 1, 1, pat[15], 0, S_RUN);
        add(0, 16'h0, 5'd0, 0, 0, 0, 1, 1, pat[14], 0, S_RUN);
        run_vecs("midreset");
        @(posedge clk);
        #2;
        check("midreset valid before", {31'd0, ser_if.ser_valid}, 32'd1);
        rst = 1'b0;
        #1;
        check("midreset {valid,bit,done,state}",
              {27'd0, ser_if.ser_valid, ser_if.serial_out, seq_done, state_out}, 32'd0);
        check("midreset seq_out", {16'd0, seq_out}, 32'd0);
        check("midreset seq_count", {24'd0, seq_count}, 32'd0);
        ser_if.ser_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        add_plain_seq(0, 16'h0, 5'd0, def_pat, 9);
        run_vecs("after_reset");
        check_regs("after_reset", 16'h0139, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
